// File: rtl/fp_console_ctrl_pkg.sv
// Shared front-panel console definitions.
// State encoding, display selects and word width.
package fp_console_ctrl_pkg;

  localparam int WORD_W = 12;

  typedef enum logic [2:0] {
    HALTED,
    LDPC,
    LDAC,
    DEP_WR,
    DEP_INC,
    STEP_WAIT,
    RUN_ISSUE,
    RUN_WAIT
  } fp_state_e;

  localparam logic [1:0] DISP_PC = 2'b00;
  localparam logic [1:0] DISP_AC = 2'b01;
  localparam logic [1:0] DISP_MB = 2'b10;
  localparam logic [1:0] DISP_SR = 2'b11;

endpackage

// File: rtl/fp_disp_mux.sv
// Registered panel display mux and link copy.
// Gives the panel a one-cycle-late view of core state.
module fp_disp_mux #(
  parameter int WORD_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dispsel,
  input  logic [WORD_W-1:0] core_pc,
  input  logic [WORD_W-1:0] core_ac,
  input  logic [WORD_W-1:0] core_mb,
  input  logic [WORD_W-1:0] swreg,
  input  logic              core_link,
  output logic [WORD_W-1:0] dispout,
  output logic              linkout
);
  import fp_console_ctrl_pkg::*;

  logic [WORD_W-1:0] r_dispout;
  logic              r_linkout;

  // Latch the selected word and the link bit each cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dispout <= '0;
      r_linkout <= 1'b0;
    end else begin
      r_linkout <= core_link;
      unique case (dispsel)
        DISP_PC: r_dispout <= core_pc;
        DISP_AC: r_dispout <= core_ac;
        DISP_MB: r_dispout <= core_mb;
        DISP_SR: r_dispout <= swreg;
      endcase
    end
  end

  assign dispout = r_dispout;
  assign linkout = r_linkout;

endmodule

// File: rtl/fp_console_ctrl.sv
// Front-panel console controller: sequences core loads,
// deposits, single steps and free running; owns run/halt.
module fp_console_ctrl #(
  parameter int WORD_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] swreg,
  input  logic [1:0]        dispsel,
  input  logic              run,
  input  logic              loadpc,
  input  logic              loadac,
  input  logic              step,
  input  logic              deposit,
  output logic [WORD_W-1:0] dispout,
  output logic              linkout,
  output logic              halt,
  input  logic [WORD_W-1:0] core_pc,
  input  logic [WORD_W-1:0] core_ac,
  input  logic [WORD_W-1:0] core_mb,
  input  logic              core_link,
  output logic              pc_load,
  output logic              ac_load,
  output logic [WORD_W-1:0] load_data,
  output logic              inst_start,
  input  logic              inst_done,
  input  logic              hlt_exec,
  output logic              mem_wr_req,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_wr_ack
);
  import fp_console_ctrl_pkg::*;

  fp_state_e         r_state;
  fp_state_e         w_next;
  logic              r_run_q;
  logic              w_run_edge;
  logic              w_from_halt;
  logic              r_pc_load;
  logic              r_ac_load;
  logic              r_inst_start;
  logic              r_mem_wr_req;
  logic              r_halt;
  logic [WORD_W-1:0] r_load_data;
  logic [WORD_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic [WORD_W-1:0] w_addr_inc;

  assign w_run_edge  = run & ~r_run_q;
  assign w_from_halt = (r_state == HALTED);
  assign w_addr_inc  = r_mem_addr + {{(WORD_W-1){1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= HALTED;
    else       r_state <= w_next;
  end

  // Next state; commands are only honoured while halted
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HALTED: begin
        if (loadpc)          w_next = LDPC;
        else if (loadac)     w_next = LDAC;
        else if (deposit)    w_next = DEP_WR;
        else if (step)       w_next = STEP_WAIT;
        else if (w_run_edge) w_next = RUN_ISSUE;
      end
      LDPC, LDAC, DEP_INC: w_next = HALTED;
      DEP_WR:    if (mem_wr_ack) w_next = DEP_INC;
      STEP_WAIT: if (inst_done)  w_next = HALTED;
      RUN_ISSUE: w_next = RUN_WAIT;
      RUN_WAIT: begin
        if (inst_done)
          w_next = (hlt_exec || !run) ? HALTED : RUN_ISSUE;
      end
      default: w_next = HALTED;
    endcase
  end

  // Run level history; starts high so a level held through reset is no edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_run_q <= 1'b1;
    else       r_run_q <= run;
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc_load    <= 1'b0;
      r_ac_load    <= 1'b0;
      r_inst_start <= 1'b0;
      r_mem_wr_req <= 1'b0;
      r_halt       <= 1'b1;
    end else begin
      r_pc_load    <= (w_next == LDPC) || (w_next == DEP_INC);
      r_ac_load    <= (w_next == LDAC);
      r_mem_wr_req <= (w_next == DEP_WR);
      r_inst_start <= (w_next == RUN_ISSUE) ||
                      (w_from_halt && (w_next == STEP_WAIT));
      r_halt       <= !((w_next == RUN_ISSUE) || (w_next == RUN_WAIT));
    end
  end

  // Load value and deposit address/data captured at command time
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_load_data <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_from_halt && ((w_next == LDPC) || (w_next == LDAC)))
        r_load_data <= swreg;
      else if ((r_state == DEP_WR) && (w_next == DEP_INC))
        r_load_data <= w_addr_inc;
      if (w_from_halt && (w_next == DEP_WR)) begin
        r_mem_addr  <= core_pc;
        r_mem_wdata <= swreg;
      end
    end
  end

  assign pc_load    = r_pc_load;
  assign ac_load    = r_ac_load;
  assign inst_start = r_inst_start;
  assign mem_wr_req = r_mem_wr_req;
  assign halt       = r_halt;
  assign load_data  = r_load_data;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  fp_disp_mux #(
    .WORD_W(WORD_W)
  ) u_disp (
    .clock     (clock),
    .reset     (reset),
    .dispsel   (dispsel),
    .core_pc   (core_pc),
    .core_ac   (core_ac),
    .core_mb   (core_mb),
    .swreg     (swreg),
    .core_link (core_link),
    .dispout   (dispout),
    .linkout   (linkout)
  );

endmodule

// File: tb/tb_fp_console_ctrl.sv
// Testbench for fp_console_ctrl: command table plus
// deposit, step, run and reset sequences.
module tb_fp_console_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] swreg;
  logic [1:0]  dispsel;
  logic        run, loadpc, loadac, step, deposit;
  logic [11:0] dispout;
  logic        linkout, halt;
  logic [11:0] core_pc, core_ac, core_mb;
  logic        core_link;
  logic        pc_load, ac_load;
  logic [11:0] load_data;
  logic        inst_start;
  logic        inst_done, hlt_exec;
  logic        mem_wr_req;
  logic [11:0] mem_addr, mem_wdata;
  logic        mem_wr_ack;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fp_console_ctrl #(.WORD_W(12)) dut (
    .clock(clock), .reset(reset), .swreg(swreg), .dispsel(dispsel),
    .run(run), .loadpc(loadpc), .loadac(loadac), .step(step),
    .deposit(deposit), .dispout(dispout), .linkout(linkout),
    .halt(halt), .core_pc(core_pc), .core_ac(core_ac),
    .core_mb(core_mb), .core_link(core_link), .pc_load(pc_load),
    .ac_load(ac_load), .load_data(load_data),
    .inst_start(inst_start), .inst_done(inst_done),
    .hlt_exec(hlt_exec), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_ack(mem_wr_ack)
  );

  typedef struct {
    logic        lpc;
    logic        lac;
    logic        stp;
    logic [11:0] sw;
    logic [1:0]  sel;
    logic        e_pc;
    logic        e_ac;
    logic        e_is;
    logic [11:0] e_ld;
    logic [11:0] e_disp;
  } vec_t;

  vec_t vt[5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk12(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %o expected %o", nm, act, exp);
    end
  endtask

  initial begin
    int seen;
    int low;
    logic [11:0] ex;

    vt[0] = '{1'b1, 1'b0, 1'b0, 12'o1234, 2'b00,
              1'b1, 1'b0, 1'b0, 12'o1234, 12'o4321};
    vt[1] = '{1'b0, 1'b1, 1'b0, 12'o0707, 2'b01,
              1'b0, 1'b1, 1'b0, 12'o0707, 12'o1111};
    vt[2] = '{1'b1, 1'b1, 1'b0, 12'o7777, 2'b10,
              1'b1, 1'b0, 1'b0, 12'o7777, 12'o2222};
    vt[3] = '{1'b0, 1'b1, 1'b1, 12'o0001, 2'b11,
              1'b0, 1'b1, 1'b0, 12'o0001, 12'o0001};
    vt[4] = '{1'b0, 1'b0, 1'b0, 12'o5252, 2'b11,
              1'b0, 1'b0, 1'b0, 12'o0000, 12'o5252};

    reset = 1'b1; swreg = 12'o0; dispsel = 2'b00;
    run = 1'b1; loadpc = 0; loadac = 0; step = 0; deposit = 0;
    core_pc = 12'o4321; core_ac = 12'o1111; core_mb = 12'o2222;
    core_link = 1'b1; inst_done = 0; hlt_exec = 0; mem_wr_ack = 0;

    tick(); tick();
    chk1("rst halt", halt, 1'b1);
    chk12("rst dispout", dispout, 12'o0);
    chk1("rst linkout", linkout, 1'b0);
    chk1("rst pc_load", pc_load, 1'b0);
    chk1("rst inst_start", inst_start, 1'b0);
    chk1("rst mem_wr_req", mem_wr_req, 1'b0);
    chk12("rst mem_addr", mem_addr, 12'o0);
    chk12("rst load_data", load_data, 12'o0);

    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_start || !halt) seen++;
    end
    chk12("run high at reset exit", 12'(seen), 12'd0);
    run = 1'b0;
    tick();
    chk1("linkout follows", linkout, 1'b1);

    for (int i = 0; i < 5; i++) begin
      loadpc = vt[i].lpc; loadac = vt[i].lac; step = vt[i].stp;
      swreg = vt[i].sw; dispsel = vt[i].sel;
      tick();
      loadpc = 0; loadac = 0; step = 0;
      chk1($sformatf("v%0d pc_load", i), pc_load, vt[i].e_pc);
      chk1($sformatf("v%0d ac_load", i), ac_load, vt[i].e_ac);
      chk1($sformatf("v%0d inst_start", i), inst_start, vt[i].e_is);
      chk1($sformatf("v%0d halt", i), halt, 1'b1);
      chk1($sformatf("v%0d mem_wr_req", i), mem_wr_req, 1'b0);
      chk12($sformatf("v%0d dispout", i), dispout, vt[i].e_disp);
      if (vt[i].e_pc || vt[i].e_ac)
        chk12($sformatf("v%0d load_data", i), load_data, vt[i].e_ld);
      tick();
      chk1($sformatf("v%0d strobe drop", i), pc_load | ac_load, 1'b0);
      tick();
    end

    core_pc = 12'o7777; swreg = 12'o0525;
    deposit = 1;
    tick();
    deposit = 0;
    core_pc = 12'o0100; swreg = 12'o0000;
    for (int c = 0; c < 3; c++) begin
      chk1($sformatf("dep req c%0d", c), mem_wr_req, 1'b1);
      chk12($sformatf("dep addr c%0d", c), mem_addr, 12'o7777);
      chk12($sformatf("dep data c%0d", c), mem_wdata, 12'o0525);
      chk1($sformatf("dep no pc_load c%0d", c), pc_load, 1'b0);
      if (c == 2) mem_wr_ack = 1;
      tick();
    end
    mem_wr_ack = 0;
    chk1("dep req drop", mem_wr_req, 1'b0);
    chk1("dep inc pc_load", pc_load, 1'b1);
    chk12("dep inc wrap", load_data, 12'o0000);
    tick();
    chk1("dep inc done", pc_load, 1'b0);
    tick();

    step = 1;
    tick();
    step = 0;
    seen = 0; low = 0;
    if (inst_start) seen++;
    if (!halt) low++;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) inst_done = 1;
      tick();
      inst_done = 0;
      if (inst_start) seen++;
      if (!halt) low++;
    end
    chk12("step start count", 12'(seen), 12'd1);
    chk12("step halt low", 12'(low), 12'd0);

    run = 1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      chk1($sformatf("run start %0d", i), inst_start, 1'b1);
      chk1($sformatf("run halt low %0d", i), halt, 1'b0);
      deposit = (i == 1);
      tick();
      deposit = 0;
      chk1($sformatf("run start drop %0d", i), inst_start, 1'b0);
      chk1($sformatf("run dep ignored %0d", i), mem_wr_req, 1'b0);
      tick();
      chk1($sformatf("run wait %0d", i), inst_start | halt, 1'b0);
      inst_done = 1; hlt_exec = (i == 3);
      tick();
      inst_done = 0; hlt_exec = 0;
    end
    chk1("run hlt halt", halt, 1'b1);
    chk1("run hlt no start", inst_start, 1'b0);
    chk1("run dep never", mem_wr_req, 1'b0);
    tick();
    chk1("run stays halted", halt, 1'b1);

    run = 0;
    tick();
    run = 1;
    tick();
    chk1("run2 start", inst_start, 1'b1);
    run = 0;
    tick();
    tick();
    chk1("run2 no abort", halt, 1'b0);
    inst_done = 1;
    tick();
    inst_done = 0;
    chk1("run2 halted", halt, 1'b1);
    chk1("run2 no start", inst_start, 1'b0);

    core_pc = 12'o0042; swreg = 12'o0777;
    deposit = 1;
    tick();
    deposit = 0;
    chk1("rdep req", mem_wr_req, 1'b1);
    #2 reset = 1;
    #1;
    chk1("rdep req async", mem_wr_req, 1'b0);
    chk12("rdep addr async", mem_addr, 12'o0);
    tick(); tick();
    reset = 0;
    mem_wr_ack = 1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      mem_wr_ack = 0;
      if (pc_load || mem_wr_req) seen++;
    end
    chk12("rdep no resume", 12'(seen), 12'd0);

    core_pc = 12'o0123; core_ac = 12'o4567;
    core_mb = 12'o7070; swreg = 12'o3456;
    for (int s = 0; s < 4; s++) begin
      dispsel = 2'(s);
      tick();
      case (s)
        0: ex = core_pc;
        1: ex = core_ac;
        2: ex = core_mb;
        default: ex = swreg;
      endcase
      chk12($sformatf("sweep sel%0d", s), dispout, ex);
    end
    core_link = 1'b0;
    tick();
    chk1("link clear", linkout, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_console_ctrl.md
# fp_console_ctrl

CPU-side master of the front-panel pin interface: consumes the debounced panel commands (load PC, load AC, deposit, single step, run) and the switch register. It sequences the CPU core and memory write port to carry those commands out. It returns the selected display word, the link and the halt status to the panel. It sits between the front-panel block and the PDP-8 core/memory, and owns the run/halt state of the machine.

## Interface
Parameters:
- WORD_W, 12, PDP-8 word/address width.

Ports (panel pins carry the shared interface's signal names):
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock, no other clock domains.
- swreg  in  12  switch register from panel.
- dispsel  in  2  display select: 00 PC, 01 AC, 10 MB, 11 SR.
- run  in  1  panel run level.
- loadpc, loadac, step, deposit  in  1 each  single-cycle command pulses.
- dispout  out  12  selected display word.
- linkout  out  1  current link bit.
- halt  out  1  1 = machine halted.
- core_pc, core_ac, core_mb  in  12 each  core register values.
- core_link  in  1  core link bit.
- pc_load, ac_load  out  1  one-cycle load strobes to core.
- load_data  out  12  value for pc_load/ac_load.
- inst_start  out  1  one-cycle "execute one instruction" pulse.
- inst_done  in  1  one-cycle completion pulse from core.
- hlt_exec  in  1  qualified by inst_done: the completed instruction was HLT.
- mem_wr_req  out  1  memory write request, level.
- mem_addr, mem_wdata  out  12 each  write address/data, stable while mem_wr_req.
- mem_wr_ack  in  1  one-cycle write acknowledge.

## Operation
- States: HALTED, LDPC, LDAC, DEP_WR, DEP_INC, STEP_WAIT, RUN_ISSUE, RUN_WAIT.
- HALTED accepts commands; pulses arriving in any other state are dropped. Priority on simultaneous commands: loadpc > loadac > deposit > step > run start.
- Run start = rising edge of run, detected against a registered copy of run, while in HALTED. A run level already high at reset exit does not start the machine.
- LDPC / LDAC: pc_load / ac_load = 1 and load_data = swreg captured at the command cycle, for one cycle. Then return to HALTED.
- DEP_WR: mem_wr_req = 1, mem_addr = core_pc, mem_wdata = swreg, all captured at the command cycle. Held until mem_wr_ack.
- DEP_INC: pc_load = 1, load_data = captured address + 1 mod 4096 (7777 wraps to 0000). Then return to HALTED.
- STEP_WAIT: one inst_start pulse on entry, then wait for inst_done and return to HALTED. halt stays 1 throughout.
- RUN_ISSUE: inst_start = 1 for one cycle, then RUN_WAIT.
- RUN_WAIT on inst_done:
  - hlt_exec = 1 or run = 0: go to HALTED.
  - Otherwise: go to RUN_ISSUE.
  - run falling mid-instruction never aborts; the machine halts after completion.
- halt = 0 only in RUN_ISSUE/RUN_WAIT.
- dispout: core_pc / core_ac / core_mb / swreg per dispsel. linkout = core_link.

## Timing
- Reset values: halt 1; dispout 0; linkout 0; all strobes, mem_wr_req, mem_addr, mem_wdata, load_data 0; state HALTED.
- All outputs are registered.
- Command pulse at cycle n gives the corresponding strobe, or mem_wr_req, at n+1.
- Deposit: ack at cycle k gives mem_wr_req = 0 and pc_load = 1 at k+1. HALTED at k+2.
- Run: edge seen at n gives halt = 0 and inst_start at n+1. inst_done at k (continuing) gives inst_start at k+1.
- Halt: stopping inst_done at k gives halt = 1 at k+1.
- dispout/linkout follow inputs with 1-cycle latency.
- Reset asserted mid-operation: mem_wr_req and strobes drop immediately (async); no pending write or increment resumes.

## Structure
- Shared CPU definitions package holds:
  - fp_state_e enum.
  - Display-select constants DISP_PC, DISP_AC, DISP_MB, DISP_SR.
  - WORD_W.
- Optional sub-module fp_disp_mux: registered 4:1 display mux plus link register. The FSM stays in fp_console_ctrl.

## Test plan
- Reset, then swreg = 0o1234, loadpc pulse -> next cycle pc_load = 1 and load_data = 0o1234; halt stays 1.
- core_pc = 0o7777, swreg = 0o0525, deposit; ack after 3 cycles -> mem_wr_req held 3 cycles with addr 0o7777 / data 0o0525; then pc_load with load_data = 0o0000.
- step pulse; inst_done 5 cycles later -> exactly one inst_start; halt never 0.
- run rising; core completes 3 instructions, third with hlt_exec = 1 -> 3 inst_start pulses, each 1 cycle after the preceding done; halt = 1 the cycle after the third done.
- loadac and step pulsed in the same cycle -> only ac_load issued. deposit pulsed while running -> ignored.
- Reset asserted during DEP_WR -> mem_wr_req = 0 immediately, no pc_load follows. dispsel sweep 00..11 -> dispout = PC, AC, MB, SR one cycle later.
